fsk8_modulator: RTL

- Continuous-phase 8-FSK baseband source that feeds the channel-noise stage.
- Accepts 3-bit symbols over a valid/ready handshake and maps each to one of 8 tone frequencies.
- Emits SAMPLES_PER_SYMBOL complex (I/Q) samples per symbol, 18-bit signed, at a programmable sample rate.
- Amplitude default leaves headroom for additive noise of up to ±3σ at σ≈9200 without overflowing 18 bits.

---
 rtl/fsk8_modulator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fsk8_modulator.sv
// Continuous-phase 8-FSK I/Q source: one pending + one active symbol slot,
// phase accumulator, and a quarter-wave sine LUT with a 2-clock output pipeline.
module fsk8_modulator #(
   parameter int SAMPLES_PER_SYMBOL = 64,
   parameter int CLKS_PER_SAMPLE    = 1,
   parameter int PHASE_W            = 16,
   parameter int FCW_BASE           = 1024,
   parameter int FCW_STEP           = 1024,
   parameter int AMP                = 32767
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sym_valid,
   input  logic [2:0]         sym_data,
   output logic               sym_ready,
   output logic               out_valid,
   output logic signed [17:0] out_i,
   output logic signed [17:0] out_q,
   output logic               sym_start,
   output logic               busy
);
   localparam int CNT_W  = $clog2(SAMPLES_PER_SYMBOL);
   localparam int DIV_W  = $clog2(CLKS_PER_SAMPLE + 1);
   localparam int STAGES = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);

   typedef logic [64:0][17:0] qlut_t;
   typedef logic [7:0][PHASE_W-1:0] fcw_t;

   // Quarter-wave magnitudes, rounded to nearest at elaboration time
   function automatic qlut_t build_qlut();
      qlut_t t;
      for (int k = 0; k <= 64; k++)
         t[k] = 18'($rtoi(real'(AMP) * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0) + 0.5));
      return t;
   endfunction

   function automatic fcw_t build_fcw();
      fcw_t t;
      for (int k = 0; k < 8; k++)
         t[k] = PHASE_W'(FCW_BASE + k * FCW_STEP);
      return t;
   endfunction

   localparam qlut_t QLUT    = build_qlut();
   localparam fcw_t  FCW_TAB = build_fcw();

   function automatic logic signed [17:0] lut_sin(input logic [7:0] a);
      logic [6:0]         idx;
      logic signed [17:0] mag;
      idx = a[6] ? 7'd64 - {1'b0, a[5:0]} : {1'b0, a[5:0]};
      mag = QLUT[idx];
      return a[7] ? -mag : mag;
   endfunction

   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;

   logic               pend_full, act_valid;
   logic [2:0]         pend_data, act_data;
   logic [PHASE_W-1:0] phase;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [STAGES:0]    vld_pipe, start_pipe;
   logic [7:0]         addr_r;
   logic signed [17:0] sin_r, cos_r;
   logic               accept, tick, last_tick, load;

   assign sym_ready = ~pend_full;
   assign accept    = sym_valid & sym_ready;
   assign tick      = (state_q == RUN) && (div_q == DIV_LAST);
   assign last_tick = tick && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: if (pend_full) begin
            load    = 1'b1;
            state_d = RUN;
         end
         RUN: if (last_tick) begin
            // a symbol arriving on the boundary edge bypasses pending
            if (pend_full || accept) load = 1'b1;
            else                     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         pend_data <= '0;
         act_valid <= 1'b0;
         act_data  <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         phase     <= '0;
      end else begin
         if (load && pend_full) pend_full <= 1'b0;
         else if (accept && !load) begin
            pend_full <= 1'b1;
            pend_data <= sym_data;
         end
         if (load) begin
            act_valid <= 1'b1;
            act_data  <= pend_full ? pend_data : sym_data;
         end else if (last_tick) act_valid <= 1'b0;
         if (state_q == IDLE) begin
            div_q <= '0;
            cnt_q <= '0;
         end else if (tick) begin
            div_q <= '0;
            cnt_q <= last_tick ? '0 : cnt_q + 1'b1;
         end else div_q <= div_q + 1'b1;
         // a seamless reload keeps the phase; only a fresh start from IDLE zeroes it
         if (state_q == IDLE && load) phase <= '0;
         else if (tick)               phase <= phase + FCW_TAB[act_data];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe   <= '0;
         start_pipe <= '0;
         addr_r     <= '0;
         sin_r      <= '0;
         cos_r      <= '0;
         out_i      <= '0;
         out_q      <= '0;
      end else begin
         vld_pipe   <= {vld_pipe[STAGES-1:0], tick};
         start_pipe <= {start_pipe[STAGES-1:0], tick && (cnt_q == '0)};
         if (tick) addr_r <= phase[PHASE_W-1 -: 8];
         sin_r <= lut_sin(addr_r);
         cos_r <= lut_sin(addr_r + 8'd64);
         if (vld_pipe[STAGES-1]) begin
            out_i <= cos_r;
            out_q <= sin_r;
         end else if (vld_pipe[STAGES] && !act_valid) begin
            out_i <= '0;
            out_q <= '0;
         end
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign sym_start = start_pipe[STAGES];
   assign busy      = act_valid | pend_full | (|vld_pipe);
endmodule
